// File: rtl/inst_encoder.sv
// RV32I encoder: packs decoded fields into a legal instruction word; 2-cycle latency.
// Valid/ready on both sides, 2-word capacity; illegal fields yield a NOP flagged with out_err.
module inst_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] out_count,
    output logic [7:0]  err_count
);

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // True when every bit from sign_bit upward matches, i.e. imm fits (sign_bit+1) signed bits.
    function automatic logic fits(input logic [31:0] imm, input int sign_bit);
        logic [31:0] t;
        t = $signed(imm) >>> sign_bit;
        return (t == '0) || (t == '1);
    endfunction

    function automatic logic is_shift(input fields_t f);
        return (f.opcode == OP_IMM) && (f.funct3[1:0] == 2'b01);
    endfunction

    function automatic logic is_legal(input fields_t f);
        logic ok;
        ok = 1'b0;
        case (f.opcode)
            OP_LOAD, OP_JALR, OP_STORE: ok = fits(f.imm, 11);
            OP_IMM: begin
                if (is_shift(f))
                    ok = (f.imm[31:5] == '0) &&
                         ((f.funct7 == 7'b0000000) ||
                          ((f.funct7 == 7'b0100000) && (f.funct3 == 3'b101)));
                else
                    ok = fits(f.imm, 11);
            end
            OP_BRANCH:       ok = fits(f.imm, 12) && !f.imm[0];
            OP_JAL:          ok = fits(f.imm, 20) && !f.imm[0];
            OP_LUI, OP_AUIPC: ok = (f.imm[11:0] == '0);
            OP_REG:          ok = 1'b1;
            default:         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] pack(input fields_t f);
        logic [31:0] w;
        w = NOP;
        case (f.opcode)
            OP_LOAD, OP_JALR:
                w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            OP_IMM: begin
                if (is_shift(f))
                    w = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
                else
                    w = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
            end
            OP_STORE:
                w = {f.imm[11:5], f.rs2, f.rs1, f.funct3, f.imm[4:0], f.opcode};
            OP_BRANCH:
                w = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                     f.imm[4:1], f.imm[11], f.opcode};
            OP_JAL:
                w = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12], f.rd, f.opcode};
            OP_LUI, OP_AUIPC:
                w = {f.imm[31:12], f.rd, f.opcode};
            OP_REG:
                w = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            default:
                w = NOP;
        endcase
        return w;
    endfunction

    fields_t in_fields;
    fields_t s1_fields;
    logic    s1_valid;
    logic    s1_legal;
    logic    s2_free;
    logic    s1_adv;
    logic    in_fire;
    logic    out_fire;

    assign in_fields = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                         funct3: in_funct3, funct7: in_funct7, imm: in_imm};

    // S2 can take a word when empty or when its current word leaves this cycle.
    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s2_free;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_fields <= '0;
            s1_legal  <= 1'b0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_fields <= in_fields;
            s1_legal  <= is_legal(in_fields);
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_inst  <= s1_legal ? pack(s1_fields) : NOP;
            out_err   <= !s1_legal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_count <= '0;
            err_count <= '0;
        end else if (out_fire) begin
            out_count <= out_count + 16'd1;
            if (out_err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized bench for inst_encoder: directed encodings plus random fields scored against a reference model.
module tb_inst_encoder;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } fld_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] out_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    inst_encoder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_err(out_err),
        .out_count(out_count), .err_count(err_count)
    );

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    exp_t q[$];
    int   dcyc[$];
    exp_t cur_exp;
    exp_t mon_e;
    int   m_out = 0;
    int   m_err = 0;
    bit   rand_rdy = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_inst;
    logic prev_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference encoder computed from the ISA field rules with plain arithmetic.
    function automatic exp_t ref_enc(input fld_t f);
        exp_t r;
        int s;
        logic [31:0] u, w, rd, rs1, rs2, f3, f7, op;
        bit ok;
        s = $signed(f.imm);
        u = f.imm;
        rd = 32'(f.rd) << 7;   rs1 = 32'(f.rs1) << 15; rs2 = 32'(f.rs2) << 20;
        f3 = 32'(f.f3) << 12;  f7 = 32'(f.f7) << 25;   op = 32'(f.op);
        w = 32'h13;
        ok = 0;
        case (f.op)
            7'h03, 7'h67: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = ((u & 32'hFFF) << 20) | rs1 | f3 | rd | op;
            end
            7'h13: begin
                if (f.f3 == 3'b001 || f.f3 == 3'b101) begin
                    ok = (u < 32) && ((f.f7 == 7'h00) || (f.f7 == 7'h20 && f.f3 == 3'b101));
                    w  = f7 | ((u & 31) << 20) | rs1 | f3 | rd | op;
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    w  = ((u & 32'hFFF) << 20) | rs1 | f3 | rd | op;
                end
            end
            7'h23: begin
                ok = (s >= -2048) && (s <= 2047);
                w  = (((u >> 5) & 127) << 25) | rs2 | rs1 | f3 | ((u & 31) << 7) | op;
            end
            7'h63: begin
                ok = (s >= -4096) && (s <= 4095) && (u[0] == 1'b0);
                w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | rs2 | rs1 | f3 |
                     (((u >> 1) & 15) << 8) | (((u >> 11) & 1) << 7) | op;
            end
            7'h6F: begin
                ok = (s >= -1048576) && (s <= 1048575) && (u[0] == 1'b0);
                w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) |
                     (((u >> 11) & 1) << 20) | (((u >> 12) & 255) << 12) | rd | op;
            end
            7'h37, 7'h17: begin
                ok = ((u & 32'hFFF) == 0);
                w  = (u & 32'hFFFFF000) | rd | op;
            end
            7'h33: begin
                ok = 1;
                w  = f7 | rs2 | rs1 | f3 | rd | op;
            end
            default: ok = 0;
        endcase
        r.inst = ok ? w : 32'h13;
        r.err  = !ok;
        return r;
    endfunction

    function automatic fld_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm);
        fld_t f;
        f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2; f.f3 = f3; f.f7 = f7; f.imm = imm;
        return f;
    endfunction

    function automatic fld_t rand_fields();
        fld_t f;
        int b;
        case ($urandom_range(0, 9))
            0: f.op = 7'h03;  1: f.op = 7'h13;  2: f.op = 7'h67;  3: f.op = 7'h23;
            4: f.op = 7'h63;  5: f.op = 7'h6F;  6: f.op = 7'h37;  7: f.op = 7'h17;
            8: f.op = 7'h33;  default: f.op = 7'($urandom);
        endcase
        f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
        f.f3 = 3'($urandom);
        case ($urandom_range(0, 2))
            0: f.f7 = 7'h00;  1: f.f7 = 7'h20;  default: f.f7 = 7'($urandom);
        endcase
        case ($urandom_range(0, 3))
            0: f.imm = 32'(int'($urandom_range(0, 64)) - 32);
            1: begin
                case ($urandom_range(0, 9))
                    0: b = 2047;     1: b = -2048;    2: b = 4095;  3: b = -4096;
                    4: b = 1048575;  5: b = -1048576; 6: b = 31;    7: b = 32'h12345000;
                    8: b = 2048;     default: b = 0;
                endcase
                f.imm = 32'(b + int'($urandom_range(0, 2)) - 1);
            end
            2: f.imm = $urandom;
            default: f.imm = $urandom & 32'hFFFFF000;
        endcase
        return f;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: records accepted words, checks each delivered word and the counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_out = 0;
            m_err = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_vld", 32'(out_valid), 32'd1);
                chk("hold_inst", out_inst, prev_inst);
                chk("hold_err", 32'(out_err), 32'(prev_err));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    mon_e = q.pop_front();
                    chk("inst", out_inst, mon_e.inst);
                    chk("err", 32'(out_err), 32'(mon_e.err));
                    chk("out_count", 32'(out_count), 32'(m_out));
                    chk("err_count", 32'(err_count), 32'(m_err));
                    m_out = (m_out + 1) % 65536;
                    if (mon_e.err && m_err < 255) m_err++;
                    dcyc.push_back(cyc);
                end
            end
            if (in_valid && in_ready) q.push_back(cur_exp);
            prev_stall = out_valid && !out_ready;
            prev_inst  = out_inst;
            prev_err   = out_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic put(input fld_t f, input exp_t e);
        in_opcode = f.op; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
        in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm;
        cur_exp = e;
        in_valid = 1'b1;
    endtask

    task automatic offer(input fld_t f, input exp_t e);
        put(f, e);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic offer_ref(input fld_t f);
        offer(f, ref_enc(f));
    endtask

    task automatic drain();
        for (int t = 0; t < 300; t++) begin
            if (q.size() == 0) break;
            tick();
        end
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    // Expects an empty pipeline, out_ready high, and entry just after a rising edge.
    task automatic lat_check(input fld_t f, input exp_t e);
        put(f, e);
        @(negedge clk);
        chk("lat_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat_edge1_vld", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_edge2_vld", 32'(out_valid), 32'd1);
        tick();
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        fld_t f;
        fld_t w[3];
        exp_t we[3];
        int d0, acc, k, cnt0;
        bit took;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0; cur_exp = '0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back stream: SW, BEQ, JAL, LUI.
        d0 = dcyc.size();
        offer(mk(7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, -32'sd4), '{32'hFE21AE23, 1'b0});
        offer(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8), '{32'h00000463, 1'b0});
        offer(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048), '{32'h001000EF, 1'b0});
        offer(mk(7'h37, 5'd10, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000), '{32'h12345537, 1'b0});
        drain();
        chk("stream_count", 32'(out_count), 32'd4);
        if (dcyc.size() >= d0 + 4)
            chk("stream_b2b_span", 32'(dcyc[d0 + 3] - dcyc[d0]), 32'd3);
        else
            chk("stream_delivered", 32'(dcyc.size() - d0), 32'd4);

        lat_check(mk(7'h13, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFFFFFF), '{32'hFFF00093, 1'b0});
        offer(mk(7'h13, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd3), '{32'h40335293, 1'b0});

        // Illegal words.
        offer(mk(7'h63, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3), '{32'h00000013, 1'b1});
        offer(mk(7'h6F, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00100000), '{32'h00000013, 1'b1});
        offer(mk(7'h7F, 5'd4, 5'd5, 5'd6, 3'b111, 7'd0, 32'd0), '{32'h00000013, 1'b1});
        drain();
        chk("err_count_3", 32'(err_count), 32'd3);
        offer(mk(7'h13, 5'd5, 5'd6, 5'd0, 3'b101, 7'b0100000, 32'd32), '{32'h00000013, 1'b1});
        for (int i = 0; i < 300; i++)
            offer(mk(7'h7F, 5'($urandom), 5'd0, 5'd0, 3'd0, 7'd0, $urandom), '{32'h00000013, 1'b1});
        drain();
        chk("err_count_sat", 32'(err_count), 32'hFF);

        // Backpressure: only two words fit while the output is stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            w[i] = rand_fields();
            we[i] = ref_enc(w[i]);
        end
        cnt0 = m_out;
        acc = 0; k = 0;
        put(w[0], we[0]);
        repeat (6) begin
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
            tick();
            if (took) begin
                k++;
                if (k < 3) put(w[k], we[k]); else in_valid = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_inst", out_inst, we[0].inst);
        tick();
        out_ready = 1'b1;
        for (int t = 0; t < 20 && k < 3; t++) begin
            @(negedge clk);
            took = in_valid && in_ready;
            tick();
            if (took) begin
                k++;
                in_valid = 1'b0;
            end
        end
        chk("bp_all_accepted", 32'(k), 32'd3);
        drain();
        chk("bp_delivered", 32'(out_count), 32'((cnt0 + 3) % 65536));

        // Random traffic with random output stalls.
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            offer_ref(rand_fields());
            repeat ($urandom_range(0, 1)) tick();
        end
        drain();
        rand_rdy = 0;

        // Reset mid-stall with both stages full.
        out_ready = 1'b0;
        offer_ref(rand_fields());
        offer_ref(rand_fields());
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_inst", out_inst, 32'd0);
        chk("midrst_out_count", 32'(out_count), 32'd0);
        chk("midrst_err_count", 32'(err_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        lat_check(mk(7'h33, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, $urandom), '{32'h002081B3, 1'b0});
        chk("post_rst_count", 32'(out_count), 32'd1);

        rand_rdy = 1;
        for (int i = 0; i < 200; i++) begin
            f = rand_fields();
            offer_ref(f);
        end
        drain();
        rand_rdy = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
